// File: rtl/serial_logic20_if.sv
// rtl/serial_logic20_if.sv - start/ready request bus and result bus of the bit-serial logic unit
// Purpose: groups the request (start, op, a, b) and the status/result
//          (ready, busy, done, result, zero) signals of serial_logic20.
// Modports:
//   master - drives start, op, a, b; observes ready, busy, done, result, zero
//   slave  - the unit itself: observes the request, drives status and result
interface serial_logic20_if #(
  parameter int WIDTH = 20
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, op, a, b,
    input  ready, busy, done, result, zero
  );

  modport slave (
    input  start, op, a, b,
    output ready, busy, done, result, zero
  );
endinterface

// File: rtl/serial_logic20.sv
// rtl/serial_logic20.sv - bit-serial 20-bit AND/OR/XOR/NOT unit, one bit per clock, LSB first
// Purpose: accepts an operation through a start/ready handshake, evaluates
//          one result bit per clock into a shift register and publishes the
//          full word with a zero flag and a one-cycle done pulse.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous, active-high reset
//   bus  - serial_logic20_if.slave:
//            start/op/a/b in (op: 00 AND, 01 OR, 10 XOR, 11 NOT a)
//            ready (IDLE), busy (RUN), done (DONE pulse), result, zero out
module serial_logic20 #(
  parameter int WIDTH = 20
) (
  input  logic            clk,
  input  logic            rst,
  serial_logic20_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             bit_val;

  // One result bit from the captured operands; b is not consulted for NOT.
  always_comb begin
    bit_val = 1'b0;
    case (op_q)
      2'b00:   bit_val = a_q[cnt] & b_q[cnt];
      2'b01:   bit_val = a_q[cnt] | b_q[cnt];
      2'b10:   bit_val = a_q[cnt] ^ b_q[cnt];
      default: bit_val = ~a_q[cnt];
    endcase
  end

  // New bit enters at the MSB; after WIDTH shifts bit 0 has reached the LSB.
  assign sr_next = {bit_val, sr[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      op_q     <= 2'b00;
      a_q      <= '0;
      b_q      <= '0;
      sr       <= '0;
      result_q <= '0;
      zero_q   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            op_q  <= bus.op;
            a_q   <= bus.a;
            b_q   <= bus.b;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sr <= sr_next;
          if (cnt == LAST) begin
            // Publish straight from sr_next so result never shows a partial word.
            result_q <= sr_next;
            zero_q   <= (sr_next == '0);
            state    <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.ready  = (state == IDLE);
  assign bus.busy   = (state == RUN);
  assign bus.done   = (state == DONE);
  assign bus.result = result_q;
  assign bus.zero   = zero_q;
endmodule

// File: tb/tb_serial_logic20.sv
// tb/tb_serial_logic20.sv - self-checking bench for serial_logic20 against a word-level reference model
module tb_serial_logic20;
  localparam int W = 20;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;
  logic [W-1:0] prev_res;

  serial_logic20_if #(.WIDTH(W)) bus ();

  serial_logic20 #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // Whole-word reference: what the combinational units would produce.
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE (cycle 0). Returns at the negedge of cycle W+2.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, input bit disturb);
    logic [W-1:0] exp;
    exp = ref_op(op, a, b);
    check("ready_c0", bus.ready, 1'b1);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      @(negedge clk);
      if (!hold && (cyc == 1 || cyc == 6 || cyc == W + 2)) bus.start = 1'b0;
      check($sformatf("busy_c%0d", cyc), bus.busy, (cyc <= W));
      check($sformatf("done_c%0d", cyc), bus.done, (cyc == W + 1));
      check($sformatf("ready_c%0d", cyc), bus.ready, (cyc == W + 2));
      if (cyc <= W) check($sformatf("hold_res_c%0d", cyc), bus.result, prev_res);
      if (cyc == W + 1) begin
        check("result", bus.result, exp);
        check("zero", bus.zero, (exp == '0));
      end
      if (disturb) begin
        if (cyc <= W) begin
          bus.a  = W'($urandom);
          bus.b  = W'($urandom);
          bus.op = 2'($urandom);
        end
        if (cyc == 5 || cyc == W + 1) bus.start = 1'b1;
      end
    end
    prev_res = exp;
  endtask

  initial begin
    n_cmp     = 0;
    n_fail    = 0;
    prev_res  = '0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.a     = '1;
    bus.b     = '1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", bus.ready, 1'b1);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_result", bus.result, 0);
    check("rst_zero", bus.zero, 1'b1);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);

    run_op(2'b00, 20'hF0F0F, 20'hFF00F, 0, 0);
    run_op(2'b10, 20'hABCDE, 20'hABCDE, 0, 0);
    run_op(2'b01, 20'h12345, 20'h80000, 0, 0);
    run_op(2'b11, 20'h00000, 20'h5A5A5, 0, 0);
    run_op(2'b11, 20'h0F0F0, W'($urandom), 0, 0);
    run_op(2'b00, 20'hFFFFF, 20'h00001, 0, 1);

    // Abort mid-RUN: start in cycle 0, reset in cycle 10.
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.a     = 20'h13579;
    bus.b     = 20'h2468A;
    for (int cyc = 1; cyc <= 9; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      check($sformatf("abort_busy_c%0d", cyc), bus.busy, 1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", bus.ready, 1'b1);
    check("abort_busy", bus.busy, 1'b0);
    check("abort_result", bus.result, 0);
    check("abort_zero", bus.zero, 1'b1);
    for (int cyc = 0; cyc < W + 5; cyc++) begin
      @(negedge clk);
      check("abort_no_done", bus.done, 1'b0);
    end
    prev_res = '0;

    // Held start: back-to-back acceptance every W+2 cycles.
    run_op(2'b10, 20'hAAAAA, 20'h55555, 1, 0);
    run_op(2'b10, 20'hAAAAA, 20'h55555, 1, 0);
    bus.start = 1'b0;
    @(negedge clk);
    check("held_idle_done", bus.done, 1'b0);
    check("held_idle_busy", bus.busy, 1'b0);

    for (int k = 0; k < 12; k++) begin
      run_op(2'($urandom), W'($urandom), W'($urandom), 0, (k % 3 == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
